// File: rtl/mem_model_pkg.sv
// Shared types and defaults for the dmem_model data-memory responder.
// Contents:
//   size_e  - SIZE encodings (word / half / byte / illegal)
//   state_e - responder FSM states
//   class_e - access classification decided when a request is accepted
//   DEF_*   - default base, STDOUT and EXIT byte addresses
package mem_model_pkg;

  typedef enum logic [1:0] {
    SZ_WORD    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_BYTE    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    CL_MEM,
    CL_STDOUT,
    CL_EXIT,
    CL_ERR
  } class_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0800_0000;
  localparam logic [31:0] DEF_STDOUT_ADDR = 32'hF000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'hFF00_0000;

endpackage

// File: rtl/dmem_model_if.sv
// Processor data-bus bundle between a master (CPU / bench) and dmem_model.
// Signals:
//   MREQ   - access request            (master -> slave)
//   WRITE  - 1 = store, 0 = load       (master -> slave)
//   SIZE   - 00 word, 01 half, 10 byte (master -> slave)
//   DAD    - byte address              (master -> slave)
//   WDT    - store data, low-aligned   (master -> slave)
//   RDT    - load data, zero-extended  (slave -> master)
//   ACKD_n - active-low completion     (slave -> master)
//   ERR    - error, valid with ACKD_n  (slave -> master)
interface dmem_model_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic [31:0] WDT;
  logic [31:0] RDT;
  logic        ACKD_n;
  logic        ERR;

  modport master (output MREQ, WRITE, SIZE, DAD, WDT, input RDT, ACKD_n, ERR);
  modport slave  (input MREQ, WRITE, SIZE, DAD, WDT, output RDT, ACKD_n, ERR);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for dmem_model.
// Ports:
//   i_word    - current array word at the addressed location
//   i_wdt     - store data (half/byte in the low bits)
//   i_size    - access size
//   i_offset  - byte offset DAD[1:0]
//   o_rdata   - addressed lanes shifted down and zero-extended
//   o_wmerge  - i_word with only the addressed lanes replaced by i_wdt
//   o_illegal - size/offset combination cannot be served
module mem_lane_align
  import mem_model_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdt,
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wmerge,
  output logic        o_illegal
);

  logic [4:0] w_shift;
  assign w_shift = {i_offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_rdata   = '0;
    o_wmerge  = i_word;
    o_illegal = 1'b0;
    case (i_size)
      SZ_WORD: begin
        o_illegal = (i_offset != 2'b00);
        o_rdata   = i_word;
        o_wmerge  = i_wdt;
      end
      SZ_HALF: begin
        o_illegal = i_offset[0];
        if (i_offset[1]) begin
          o_rdata[15:0]   = i_word[31:16];
          o_wmerge[31:16] = i_wdt[15:0];
        end else begin
          o_rdata[15:0]   = i_word[15:0];
          o_wmerge[15:0]  = i_wdt[15:0];
        end
      end
      SZ_BYTE: begin
        o_rdata[7:0]          = i_word[w_shift +: 8];
        o_wmerge[w_shift +: 8] = i_wdt[7:0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_model.sv
// Data-memory responder: serves one load/store at a time and acknowledges
// with an active-low strobe LATENCY cycles after acceptance. Also decodes
// STDOUT / EXIT registers and tracks the highest in-range address touched.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   bus          - dmem_model_if slave (MREQ/WRITE/SIZE/DAD/WDT/RDT/ACKD_n/ERR)
//   stdout_valid - one-cycle strobe in the ACK cycle of a STDOUT store
//   stdout_data  - character from that store
//   exit_flag    - sticky, set by a store to EXIT_ADDR
//   exit_code    - data of the EXIT store
//   max_addr     - highest legal in-range byte address accessed
module dmem_model
  import mem_model_pkg::*;
#(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned DEPTH_WORDS = 2097152,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
  parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR,
  parameter string       INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          rst,
  dmem_model_if.slave   bus,
  output logic          stdout_valid,
  output logic [7:0]    stdout_data,
  output logic          exit_flag,
  output logic [31:0]   exit_code,
  output logic [31:0]   max_addr
);

  localparam int unsigned CW    = $clog2(LATENCY + 1);
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  size_e         r_size;
  logic [31:0]   r_dad;
  logic [31:0]   r_wdt;
  logic          r_ackd_n;
  logic          r_err;
  logic [31:0]   r_rdt;
  logic          r_stdout_valid;
  logic [7:0]    r_stdout_data;
  logic          r_exit_flag;
  logic [31:0]   r_exit_code;
  logic [31:0]   r_max_addr;
  logic [31:0]   r_mem [DEPTH_WORDS];

  // In IDLE the live bus is decoded (LATENCY=1 enters ACK on the accept
  // edge); afterwards only the latched copies are used.
  logic        w_idle;
  logic        w_sel_write;
  size_e       w_sel_size;
  logic [31:0] w_sel_dad;
  logic [31:0] w_sel_wdt;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_rdata;
  logic [31:0] w_wmerge;
  logic        w_illegal;
  logic        w_in_range;
  class_e      w_class;
  logic        w_enter_ack;

  assign w_idle      = (r_state == IDLE);
  assign w_sel_write = w_idle ? bus.WRITE         : r_write;
  assign w_sel_size  = w_idle ? size_e'(bus.SIZE) : r_size;
  assign w_sel_dad   = w_idle ? bus.DAD           : r_dad;
  assign w_sel_wdt   = w_idle ? bus.WDT           : r_wdt;
  assign w_idx       = AW'((w_sel_dad - BASE_ADDR) >> 2);
  assign w_word      = r_mem[w_idx];
  assign w_in_range  = (w_sel_dad >= BASE_ADDR) && ({1'b0, w_sel_dad} < LIMIT);

  mem_lane_align u_align (
    .i_word    (w_word),
    .i_wdt     (w_sel_wdt),
    .i_size    (w_sel_size),
    .i_offset  (w_sel_dad[1:0]),
    .o_rdata   (w_rdata),
    .o_wmerge  (w_wmerge),
    .o_illegal (w_illegal)
  );

  // Priority: MMIO beats illegal alignment beats range check.
  always_comb begin
    w_class = CL_MEM;
    if (w_sel_dad == STDOUT_ADDR)        w_class = CL_STDOUT;
    else if (w_sel_dad == EXIT_ADDR)     w_class = CL_EXIT;
    else if (w_illegal || !w_in_range)   w_class = CL_ERR;
  end

  // Edge that makes the next cycle the ACK cycle; RDT/ERR/stdout are
  // registered here so they are valid exactly while ACKD_n is low.
  assign w_enter_ack = (w_idle && bus.MREQ && (LATENCY == 1)) ||
                       ((r_state == WAIT) && (r_cnt == CW'(1)));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_write        <= 1'b0;
      r_size         <= SZ_WORD;
      r_dad          <= '0;
      r_wdt          <= '0;
      r_ackd_n       <= 1'b1;
      r_err          <= 1'b0;
      r_rdt          <= '0;
      r_stdout_valid <= 1'b0;
      r_stdout_data  <= '0;
      r_exit_flag    <= 1'b0;
      r_exit_code    <= '0;
      r_max_addr     <= '0;
    end else begin
      r_ackd_n       <= 1'b1;
      r_err          <= 1'b0;
      r_rdt          <= '0;
      r_stdout_valid <= 1'b0;
      if (w_enter_ack) begin
        r_ackd_n <= 1'b0;
        r_err    <= (w_class == CL_ERR);
        if (w_class == CL_MEM && !w_sel_write) r_rdt <= w_rdata;
        if (w_class == CL_STDOUT && w_sel_write) begin
          r_stdout_valid <= 1'b1;
          r_stdout_data  <= w_sel_wdt[7:0];
        end
      end
      case (r_state)
        IDLE: begin
          if (bus.MREQ) begin
            r_write <= bus.WRITE;
            r_size  <= size_e'(bus.SIZE);
            r_dad   <= bus.DAD;
            r_wdt   <= bus.WDT;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? ACK : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ACK;
        end
        ACK: begin
          // MREQ is deliberately ignored here; the next accept is in IDLE.
          if (w_class == CL_EXIT && r_write) begin
            r_exit_flag <= 1'b1;
            r_exit_code <= r_wdt;
          end
          if (w_class == CL_MEM && r_dad > r_max_addr) r_max_addr <= r_dad;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; a reset in ACK only suppresses the pending store.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ACK && w_class == CL_MEM && r_write) r_mem[w_idx] <= w_wmerge;
  end

  assign bus.RDT      = r_rdt;
  assign bus.ACKD_n   = r_ackd_n;
  assign bus.ERR      = r_err;
  assign stdout_valid = r_stdout_valid;
  assign stdout_data  = r_stdout_data;
  assign exit_flag    = r_exit_flag;
  assign exit_code    = r_exit_code;
  assign max_addr     = r_max_addr;

endmodule

// File: tb/tb_dmem_model.sv
module tb_dmem_model;
  import mem_model_pkg::*;

  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0800_0000;
  localparam logic [31:0] STDOUT = 32'hF000_0000;
  localparam logic [31:0] EXIT   = 32'hFF00_0000;
  localparam logic [31:0] WIN    = 32'h0800_0100;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic        sv_v [3];
  logic [7:0]  sd_v [3];
  logic        ef_v [3];
  logic [31:0] ec_v [3];
  logic [31:0] ma_v [3];

  int total = 0;
  int bad   = 0;

  // Reference model state: byte-addressed memory keyed by {dut, address}.
  logic [7:0]  mb [logic [33:0]];
  logic [31:0] m_max [3];

  always #5 clk = ~clk;

  dmem_model_if bus0 ();
  dmem_model_if bus1 ();
  dmem_model_if bus2 ();

  dmem_model #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(bus0), .stdout_valid(sv_v[0]), .stdout_data(sd_v[0]),
    .exit_flag(ef_v[0]), .exit_code(ec_v[0]), .max_addr(ma_v[0]));
  dmem_model #(.LATENCY(4), .DEPTH_WORDS(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(bus1), .stdout_valid(sv_v[1]), .stdout_data(sd_v[1]),
    .exit_flag(ef_v[1]), .exit_code(ec_v[1]), .max_addr(ma_v[1]));
  dmem_model #(.LATENCY(3), .DEPTH_WORDS(DEPTH)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .bus(bus2), .stdout_valid(sv_v[2]), .stdout_data(sd_v[2]),
    .exit_flag(ef_v[2]), .exit_code(ec_v[2]), .max_addr(ma_v[2]));

  function automatic int lat_of(input int w);
    case (w)
      0:       lat_of = 1;
      1:       lat_of = 4;
      default: lat_of = 3;
    endcase
  endfunction

  function automatic logic get_ack(input int w);
    case (w)
      0:       get_ack = bus0.ACKD_n;
      1:       get_ack = bus1.ACKD_n;
      default: get_ack = bus2.ACKD_n;
    endcase
  endfunction

  function automatic logic get_err(input int w);
    case (w)
      0:       get_err = bus0.ERR;
      1:       get_err = bus1.ERR;
      default: get_err = bus2.ERR;
    endcase
  endfunction

  function automatic logic [31:0] get_rdt(input int w);
    case (w)
      0:       get_rdt = bus0.RDT;
      1:       get_rdt = bus1.RDT;
      default: get_rdt = bus2.RDT;
    endcase
  endfunction

  task automatic set_req(input int w, input logic m, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    case (w)
      0: begin bus0.MREQ = m; bus0.WRITE = wr; bus0.SIZE = sz; bus0.DAD = a; bus0.WDT = d; end
      1: begin bus1.MREQ = m; bus1.WRITE = wr; bus1.SIZE = sz; bus1.DAD = a; bus1.WDT = d; end
      default: begin bus2.MREQ = m; bus2.WRITE = wr; bus2.SIZE = sz; bus2.DAD = a; bus2.WDT = d; end
    endcase
  endtask

  // Behavioural reference: what one access should return, from the bus rules.
  task automatic model(input int w, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rdt, output logic err,
                       output logic sv, output logic [7:0] sd);
    int n;
    logic [33:0] key;
    rdt = '0; err = 1'b0; sv = 1'b0; sd = '0;
    if (a == STDOUT || a == EXIT) begin
      if (wr && a == STDOUT) begin sv = 1'b1; sd = d[7:0]; end
      return;
    end
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 0;
    if (n == 0 || (a % n) != 0 || a < BASE || a >= BASE + 4 * DEPTH) begin
      err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      key = {2'(w), a + 32'(k)};
      if (wr) mb[key] = d[8*k +: 8];
      else    rdt[8*k +: 8] = mb.exists(key) ? mb[key] : 8'hxx;
    end
    if (a > m_max[w]) m_max[w] = a;
  endtask

  // Drive one request, scramble the bus after acceptance, and capture the ACK cycle.
  task automatic access(input int w, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdt, output logic err,
                        output logic sv, output logic [7:0] sd, output int lat);
    rdt = '0; err = 1'b0; sv = 1'b0; sd = '0; lat = 0;
    set_req(w, 1'b1, wr, sz, a, d);
    @(posedge clk); #1;
    set_req(w, 1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom);
    for (int i = 1; i <= 20; i++) begin
      if (get_ack(w) === 1'b0) begin
        lat = i; rdt = get_rdt(w); err = get_err(w); sv = sv_v[w]; sd = sd_v[w];
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL ack_timeout dut=%0d addr=%h no ACK within 20 cycles", w, a);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input int w, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rdt, output logic err,
                       output logic sv, output logic [7:0] sd, output int lat,
                       output logic [31:0] e_rdt, output logic e_err, output logic e_sv,
                       output logic [7:0] e_sd);
    model(w, wr, sz, a, d, e_rdt, e_err, e_sv, e_sd);
    access(w, wr, sz, a, d, rdt, err, sv, sd, lat);
  endtask

  task automatic test_reset();
    for (int w = 0; w < 3; w++) begin
      total++;
      if ({get_ack(w), get_err(w), get_rdt(w), sv_v[w], sd_v[w], ef_v[w], ec_v[w], ma_v[w]} !==
          {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0, 32'h0}) begin
        bad++;
        $display("FAIL reset dut=%0d ack=%b err=%b rdt=%h sv=%b sd=%h ef=%b ec=%h max=%h, want 1 0 0 0 0 0 0 0",
                 w, get_ack(w), get_err(w), get_rdt(w), sv_v[w], sd_v[w], ef_v[w], ec_v[w], ma_v[w]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rdt, e_rdt; logic err, e_err, sv, e_sv; logic [7:0] sd, e_sd; int lat;
    logic [31:0] want;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin do_op(0, 1, SZ_WORD, 32'h0800_0010, 32'hDEADBEEF, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'h0; end
        1: begin do_op(0, 0, SZ_WORD, 32'h0800_0010, 32'h0,        rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'hDEADBEEF; end
        2: begin do_op(0, 1, SZ_BYTE, 32'h0800_0012, 32'h0000_005A, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'h0; end
        3: begin do_op(0, 0, SZ_WORD, 32'h0800_0010, 32'h0,        rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'hDE5ABEEF; end
        4: begin do_op(0, 0, SZ_HALF, 32'h0800_0010, 32'h0,        rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'h0000BEEF; end
        5: begin do_op(0, 0, SZ_HALF, 32'h0800_0012, 32'h0,        rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'h0000DE5A; end
        default: begin do_op(0, 0, SZ_BYTE, 32'h0800_0013, 32'h0,  rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd); want = 32'h0000_00DE; end
      endcase
      total++;
      if ({lat, err, rdt} !== {32'sd1, 1'b0, want}) begin
        bad++;
        $display("FAIL basic_%0d lat=%0d err=%b rdt=%h, want lat=1 err=0 rdt=%h", i, lat, err, rdt, want);
      end
    end
    total++;
    if (ma_v[0] !== 32'h0800_0013) begin
      bad++; $display("FAIL basic_max got=%h want=08000013", ma_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdt, e_rdt; logic err, e_err, sv, e_sv; logic [7:0] sd, e_sd; int lat;
    int ack_cnt, first, second;
    do_op(1, 1, SZ_WORD, 32'h0800_0020, 32'hCAFEF00D, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    model(1, 0, SZ_WORD, 32'h0800_0020, 0, e_rdt, e_err, e_sv, e_sd);
    model(1, 0, SZ_WORD, 32'h0800_0020, 0, e_rdt, e_err, e_sv, e_sd);
    ack_cnt = 0; first = -1; second = -1;
    set_req(1, 1'b1, 1'b0, SZ_WORD, 32'h0800_0020, 32'h0);
    for (int i = 0; i <= 14; i++) begin
      if (i == 10) set_req(1, 1'b0, 1'b0, SZ_WORD, 32'h0800_0020, 32'h0);
      if (get_ack(1) === 1'b0) begin
        ack_cnt++;
        if (first < 0) first = i; else if (second < 0) second = i;
        total++;
        if (get_rdt(1) !== 32'hCAFEF00D) begin
          bad++; $display("FAIL b2b_rdt cycle=%0d got=%h want=cafef00d", i, get_rdt(1));
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (ack_cnt != 2 || first != 4 || second != 9) begin
      bad++;
      $display("FAIL b2b_timing acks=%0d at %0d,%0d want 2 acks at 4,9", ack_cnt, first, second);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rdt, e_rdt; logic err, e_err, sv, e_sv; logic [7:0] sd, e_sd; int lat;
    logic [31:0] max_before;
    do_op(1, 1, SZ_WORD, BASE, 32'hA5A5A5A5, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    max_before = m_max[1];
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: do_op(1, 0, SZ_HALF,    32'h0800_0011, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
        1: do_op(1, 0, SZ_WORD,    32'h0800_0002, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
        2: do_op(1, 0, SZ_ILLEGAL, 32'h0800_0010, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
        3: do_op(1, 0, SZ_WORD,    32'h0000_0000, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
        default: do_op(1, 1, SZ_BYTE, BASE + 4 * DEPTH, 32'h77, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
      endcase
      total++;
      if ({lat, err, rdt} !== {32'sd4, 1'b1, 32'h0}) begin
        bad++; $display("FAIL err_%0d lat=%0d err=%b rdt=%h, want lat=4 err=1 rdt=0", i, lat, err, rdt);
      end
    end
    total++;
    if (ma_v[1] !== max_before) begin
      bad++; $display("FAIL err_max got=%h want=%h", ma_v[1], max_before);
    end
    do_op(1, 0, SZ_WORD, BASE, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if (rdt !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL err_no_write got=%h want=a5a5a5a5", rdt);
    end
  endtask

  task automatic test_mmio();
    logic [31:0] rdt, e_rdt; logic err, e_err, sv, e_sv; logic [7:0] sd, e_sd; int lat;
    do_op(0, 1, SZ_BYTE, STDOUT, 32'h48, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({err, sv, sd} !== {1'b0, 1'b1, 8'h48}) begin
      bad++; $display("FAIL stdout_H err=%b valid=%b data=%h want 0 1 48", err, sv, sd);
    end
    do_op(0, 1, SZ_BYTE, STDOUT, 32'h69, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({err, sv, sd} !== {1'b0, 1'b1, 8'h69}) begin
      bad++; $display("FAIL stdout_i err=%b valid=%b data=%h want 0 1 69", err, sv, sd);
    end
    total++;
    if (sv_v[0] !== 1'b0) begin
      bad++; $display("FAIL stdout_pulse valid=%b after ACK, want 0", sv_v[0]);
    end
    do_op(0, 0, SZ_WORD, STDOUT, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({err, sv, rdt} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL mmio_load err=%b valid=%b rdt=%h want 0 0 0", err, sv, rdt);
    end
    do_op(0, 1, SZ_WORD, EXIT, 32'h0000_0007, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({err, ef_v[0], ec_v[0]} !== {1'b0, 1'b1, 32'h7}) begin
      bad++; $display("FAIL exit err=%b flag=%b code=%h want 0 1 7", err, ef_v[0], ec_v[0]);
    end
    do_op(0, 0, SZ_WORD, 32'h0800_0010, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({rdt, ef_v[0], ec_v[0], ma_v[0]} !== {32'hDE5ABEEF, 1'b1, 32'h7, 32'h0800_0013}) begin
      bad++;
      $display("FAIL exit_sticky rdt=%h flag=%b code=%h max=%h want de5abeef 1 7 08000013",
               rdt, ef_v[0], ec_v[0], ma_v[0]);
    end
  endtask

  task automatic test_random(input int w);
    logic [31:0] rdt, e_rdt, a, d; logic err, e_err, sv, e_sv, wr; logic [7:0] sd, e_sd;
    logic [1:0] sz; int lat, r;
    for (int i = 0; i < 16; i++)
      do_op(w, 1, SZ_WORD, WIN + 32'(4 * i), $urandom, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      wr = 1'($urandom);
      d  = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? SZ_ILLEGAL : 2'($urandom_range(0, 2));
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0;
          1:       a = BASE - 4;
          2:       a = BASE + 4 * DEPTH;
          default: a = 32'h1234_5678;
        endcase
      end else if (r == 1) begin
        a = STDOUT;
      end else begin
        a = WIN + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0)
          a = (sz == SZ_WORD) ? {a[31:2], 2'b00} : (sz == SZ_HALF) ? {a[31:1], 1'b0} : a;
      end
      do_op(w, wr, sz, a, d, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
      total++;
      if ({lat, err, rdt, sv} !== {lat_of(w), e_err, e_rdt, e_sv} || (e_sv && sd !== e_sd)) begin
        bad++;
        $display("FAIL rnd dut=%0d op=%0d wr=%b sz=%0d a=%h got lat=%0d err=%b rdt=%h sv=%b sd=%h want lat=%0d err=%b rdt=%h sv=%b sd=%h",
                 w, i, wr, sz, a, lat, err, rdt, sv, sd, lat_of(w), e_err, e_rdt, e_sv, e_sd);
      end
      total++;
      if (ma_v[w] !== m_max[w]) begin
        bad++; $display("FAIL rnd_max dut=%0d op=%0d got=%h want=%h", w, i, ma_v[w], m_max[w]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rdt, e_rdt; logic err, e_err, sv, e_sv; logic [7:0] sd, e_sd; int lat, stray;
    do_op(2, 1, SZ_WORD, 32'h0800_0040, 32'h1111_1111, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    set_req(2, 1'b1, 1'b1, SZ_WORD, 32'h0800_0040, 32'h2222_2222);
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    rst_v[2] = 1'b1;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    m_max[2] = '0;
    total++;
    if ({get_ack(2), get_err(2), get_rdt(2), sv_v[2], sd_v[2], ef_v[2], ec_v[2], ma_v[2]} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL abort_outputs ack=%b err=%b rdt=%h sv=%b max=%h want reset values",
               get_ack(2), get_err(2), get_rdt(2), sv_v[2], ma_v[2]);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (get_ack(2) === 1'b0) stray++;
      @(posedge clk); #1;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL abort_no_ack got %0d stray ACK cycles want 0", stray);
    end
    do_op(2, 0, SZ_WORD, 32'h0800_0040, 0, rdt, err, sv, sd, lat, e_rdt, e_err, e_sv, e_sd);
    total++;
    if ({lat, err, rdt, ma_v[2]} !== {32'sd3, 1'b0, 32'h1111_1111, 32'h0800_0040}) begin
      bad++;
      $display("FAIL abort_reread lat=%0d err=%b rdt=%h max=%h want 3 0 11111111 08000040",
               lat, err, rdt, ma_v[2]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 3'b111;
    for (int w = 0; w < 3; w++) begin
      set_req(w, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
      m_max[w] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v = 3'b000;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_mmio();
    test_random(0);
    test_random(1);
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
